// File: rtl/reg_file.sv
// Register file with one registered read port and direct outputs for registers 0..3.
// Registers 0..3 carry ALU operands, UART configuration and the clock divider ratio.
module reg_file #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WrEn,
   input  logic                  RdEn,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] RdData,
   output logic                  RdData_Valid,
   output logic [DATA_WIDTH-1:0] REG0,
   output logic [DATA_WIDTH-1:0] REG1,
   output logic [DATA_WIDTH-1:0] REG2,
   output logic [DATA_WIDTH-1:0] REG3
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Power-on UART config: prescale 32, parity enabled, even parity; divider ratio 32.
   localparam logic [DATA_WIDTH-1:0] REG2_INIT = DATA_WIDTH'(8'b1000_0001);
   localparam logic [DATA_WIDTH-1:0] REG3_INIT = DATA_WIDTH'(8'h20);

   logic [DATA_WIDTH-1:0] regs [DEPTH];

   // NOTE: this storage is reset because registers 2 and 3 feed live configuration
   // on their side outputs; an unreset array would hand X to the UART and divider.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         regs[2]      <= REG2_INIT;
         regs[3]      <= REG3_INIT;
         RdData       <= '0;
         RdData_Valid <= 1'b0;
      end else begin
         RdData_Valid <= 1'b0;
         if (WrEn) begin
            // A write wins over a simultaneous read; the read is dropped.
            regs[Address] <= WrData;
         end else if (RdEn) begin
            RdData       <= regs[Address];
            RdData_Valid <= 1'b1;
         end
      end
   end

   assign REG0 = regs[0];
   assign REG1 = regs[1];
   assign REG2 = regs[2];
   assign REG3 = regs[3];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic,
// compared every cycle against an array-based model of the register file.
module tb_reg_file;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] address;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [DW-1:0] reg0, reg1, reg2, reg3;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_rd;
   logic          exp_valid;

   reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK          (clk),
      .RST          (rst),
      .WrEn         (wr_en),
      .RdEn         (rd_en),
      .Address      (address),
      .WrData       (wr_data),
      .RdData       (rd_data),
      .RdData_Valid (rd_valid),
      .REG0         (reg0),
      .REG1         (reg1),
      .REG2         (reg2),
      .REG3         (reg3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock: apply inputs, let the edge happen, advance the model, compare all outputs.
   task automatic step(input logic r, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      rst     = r;
      wr_en   = we;
      rd_en   = re;
      address = a;
      wr_data = d;
      @(posedge clk);
      if (!r) begin
         foreach (model_mem[i]) model_mem[i] = '0;
         model_mem[2] = 8'h81;
         model_mem[3] = 8'h20;
         exp_rd    = '0;
         exp_valid = 1'b0;
      end else begin
         exp_valid = 1'b0;
         if (we) begin
            model_mem[a] = d;
         end else if (re) begin
            exp_rd    = model_mem[a];
            exp_valid = 1'b1;
         end
      end
      #1;
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("rd_valid", 32'(rd_valid), 32'(exp_valid));
      check("reg0", 32'(reg0), 32'(model_mem[0]));
      check("reg1", 32'(reg1), 32'(model_mem[1]));
      check("reg2", 32'(reg2), 32'(model_mem[2]));
      check("reg3", 32'(reg3), 32'(model_mem[3]));
   endtask

   initial begin
      logic [DW-1:0] boot_reads [5];
      logic          r, we, re;
      boot_reads = '{8'h00, 8'h00, 8'h81, 8'h20, 8'h00};

      // Reset and power-on values
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 4'd5, 8'hAA);
      check("reset_rd_data", 32'(rd_data), 32'h0);
      check("reset_valid", 32'(rd_valid), 32'h0);
      check("reset_reg2", 32'(reg2), 32'h81);
      check("reset_reg3", 32'(reg3), 32'h20);

      // Back-to-back reads of 0..4 right after reset
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1, AW'(i), 8'h00);
         check("boot_read", 32'(rd_data), 32'(boot_reads[i]));
         check("boot_valid", 32'(rd_valid), 32'h1);
      end

      // Operand writes and readback
      step(1'b1, 1'b1, 1'b0, 4'd0, 8'h5A);
      check("reg0_write", 32'(reg0), 32'h5A);
      check("valid_after_write", 32'(rd_valid), 32'h0);
      step(1'b1, 1'b1, 1'b0, 4'd1, 8'hC3);
      check("reg1_write", 32'(reg1), 32'hC3);
      step(1'b1, 1'b0, 1'b1, 4'd1, 8'h00);
      check("read_after_write", 32'(rd_data), 32'hC3);
      check("read_after_write_valid", 32'(rd_valid), 32'h1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
      check("single_pulse", 32'(rd_valid), 32'h0);

      // Simultaneous write and read: read dropped
      step(1'b1, 1'b1, 1'b1, 4'd7, 8'h3C);
      check("collide_valid", 32'(rd_valid), 32'h0);
      check("collide_rd_held", 32'(rd_data), 32'hC3);
      step(1'b1, 1'b0, 1'b1, 4'd7, 8'h00);
      check("collide_readback", 32'(rd_data), 32'h3C);

      // Top address
      step(1'b1, 1'b1, 1'b0, 4'd15, 8'hFF);
      step(1'b1, 1'b0, 1'b1, 4'd15, 8'h00);
      check("addr15_read", 32'(rd_data), 32'hFF);
      check("addr15_valid", 32'(rd_valid), 32'h1);

      // Reset overrides a pending read and a prior write to register 3
      step(1'b1, 1'b1, 1'b0, 4'd3, 8'h10);
      check("reg3_written", 32'(reg3), 32'h10);
      step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
      check("reset_reg3_restored", 32'(reg3), 32'h20);
      check("reset_read_dropped", 32'(rd_valid), 32'h0);
      step(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      check("post_reset_no_pulse", 32'(rd_valid), 32'h0);

      // Idle hold after a read
      step(1'b1, 1'b0, 1'b1, 4'd2, 8'h00);
      check("cfg_read", 32'(rd_data), 32'h81);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, AW'($urandom_range(15)), DW'($urandom));
         check("idle_hold", 32'(rd_data), 32'h81);
         check("idle_valid", 32'(rd_valid), 32'h0);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(39) != 0);
         we = ($urandom_range(2) == 0);
         re = ($urandom_range(1) == 0);
         step(r, we, re, AW'($urandom_range(15)), DW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
